// File: rtl/mips_defines_pkg.sv
// Shared MIPS defines: regfile geometry and writeback select encoding.
// Used by wb_arbiter and the regfile.
package mips_defines_pkg;

  localparam int unsigned MipsWidth   = 32;
  localparam int unsigned MipsDepth   = 32;
  localparam int unsigned MipsZeroReg = 0;

  typedef enum logic [1:0] {
    SelNone,
    SelAlu,
    SelLoad
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Load-return queue: QDEPTH-entry FIFO with independent push/pop and occupancy count.
module wb_fifo #(
  parameter int unsigned EW     = 37,
  parameter int unsigned QDEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [EW-1:0] mem [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(QDEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile writeback arbiter: ALU writes always win, load returns queue behind them,
// and a per-register scoreboard tracks outstanding loads.
module wb_arbiter
  import mips_defines_pkg::*;
#(
  parameter int unsigned WIDTH  = MipsWidth,
  parameter int unsigned DEPTH  = MipsDepth,
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_wa,
  input  logic [WIDTH-1:0] alu_wd,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_issue_rd,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_wa,
  input  logic [WIDTH-1:0] ld_wd,
  output logic             WE,
  output logic [AW-1:0]    WA,
  output logic [WIDTH-1:0] WD,
  output logic [DEPTH-1:0] busy
);

  localparam logic [AW-1:0] ZeroAddr = AW'(MipsZeroReg);

  logic [AW+WIDTH-1:0] q_head;
  logic                q_full, q_empty, q_push, q_pop;
  logic [AW-1:0]       head_wa;
  logic [WIDTH-1:0]    head_wd;

  wb_sel_e             sel;
  logic [AW-1:0]       sel_wa;
  logic [WIDTH-1:0]    sel_wd;

  logic                we_q;
  logic [AW-1:0]       wa_q;
  logic [WIDTH-1:0]    wd_q;
  logic [DEPTH-1:0]    busy_q, busy_d;

  assign head_wa  = q_head[AW+WIDTH-1:WIDTH];
  assign head_wd  = q_head[WIDTH-1:0];
  assign ld_ready = ~q_full;
  assign q_push   = ld_valid & ld_ready;
  assign q_pop    = (sel == SelLoad);

  wb_fifo #(
    .EW    (AW + WIDTH),
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (q_push),
    .pop  (q_pop),
    .din  ({ld_wa, ld_wd}),
    .head (q_head),
    .full (q_full),
    .empty(q_empty)
  );

  always_comb begin
    sel    = SelNone;
    sel_wa = alu_wa;
    sel_wd = alu_wd;
    if (alu_valid)     sel = SelAlu;
    else if (!q_empty) sel = SelLoad;
    unique case (sel)
      SelLoad: begin
        sel_wa = head_wa;
        sel_wd = head_wd;
      end
      default: ;
    endcase
  end

  // Clear on pop first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (q_pop) busy_d[head_wa] = 1'b0;
    if (ld_issue && ld_issue_rd != ZeroAddr) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= (sel != SelNone) && (sel_wa != ZeroAddr);
      wa_q   <= sel_wa;
      wd_q   <= sel_wd;
      busy_q <= busy_d;
    end
  end

  assign WE   = we_q;
  assign WA   = wa_q;
  assign WD   = wd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed expectations checked with immediate assertions.
module tb_wb_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             alu_valid;
  logic [AW-1:0]    alu_wa;
  logic [WIDTH-1:0] alu_wd;
  logic             ld_issue;
  logic [AW-1:0]    ld_issue_rd;
  logic             ld_valid;
  logic             ld_ready;
  logic [AW-1:0]    ld_wa;
  logic [WIDTH-1:0] ld_wd;
  logic             WE;
  logic [AW-1:0]    WA;
  logic [WIDTH-1:0] WD;
  logic [DEPTH-1:0] busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wb_arbiter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .QDEPTH(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_wa     (alu_wa),
    .alu_wd     (alu_wd),
    .ld_issue   (ld_issue),
    .ld_issue_rd(ld_issue_rd),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_wa      (ld_wa),
    .ld_wd      (ld_wd),
    .WE         (WE),
    .WA         (WA),
    .WD         (WD),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [AW-1:0] wa,
                          input logic [WIDTH-1:0] wd);
    check({tag, "_we"}, 64'(WE), 64'(we));
    check({tag, "_wa"}, 64'(WA), 64'(wa));
    check({tag, "_wd"}, 64'(WD), 64'(wd));
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    ld_issue = 1'b0; ld_issue_rd = '0; ld_valid = 1'b0; ld_wa = '0; ld_wd = '0;
    step(); step();
    reset = 1'b0;
    check("rst_we", 64'(WE), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(ld_ready), 64'(1));

    // Single ALU write
    alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check_wb("alu1", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check("alu1_off", 64'(WE), 64'(0));

    // Load issue, return 3 cycles later, writeback 2 cycles after handshake
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    check("ld_busy_set", 64'(busy), 64'(32'h80));
    step(); step();
    ld_valid = 1'b1; ld_wa = 5'd7; ld_wd = 32'h1234;
    check("ld_ready", 64'(ld_ready), 64'(1));
    step();
    ld_valid = 1'b0;
    check("ld_hs1_we", 64'(WE), 64'(0));
    check("ld_hs1_busy", 64'(busy), 64'(32'h80));
    step();
    check_wb("ld_wb", 1'b1, 5'd7, 32'h1234);
    check("ld_busy_clr", 64'(busy), 64'(0));
    step();
    check("ld_wb_off", 64'(WE), 64'(0));

    // ALU held 4 cycles while 3 loads return
    alu_valid = 1'b1; alu_wa = 5'd1; alu_wd = 32'h11;
    ld_valid = 1'b1; ld_wa = 5'd2; ld_wd = 32'h22;
    check("mix_rdy0", 64'(ld_ready), 64'(1));
    step();
    check_wb("mix_a1", 1'b1, 5'd1, 32'h11);
    alu_wa = 5'd3; alu_wd = 32'h33; ld_wa = 5'd4; ld_wd = 32'h44;
    check("mix_rdy1", 64'(ld_ready), 64'(1));
    step();
    check_wb("mix_a3", 1'b1, 5'd3, 32'h33);
    alu_wa = 5'd5; alu_wd = 32'h55; ld_wa = 5'd6; ld_wd = 32'h66;
    check("mix_rdy_full", 64'(ld_ready), 64'(0));
    step();
    check_wb("mix_a5", 1'b1, 5'd5, 32'h55);
    alu_wa = 5'd8; alu_wd = 32'h88;
    check("mix_rdy_full2", 64'(ld_ready), 64'(0));
    step();
    check_wb("mix_a8", 1'b1, 5'd8, 32'h88);
    alu_valid = 1'b0;
    check("mix_rdy_nopop", 64'(ld_ready), 64'(0));
    step();
    check_wb("mix_l2", 1'b1, 5'd2, 32'h22);
    check("mix_rdy_after_pop", 64'(ld_ready), 64'(1));
    step();
    ld_valid = 1'b0;
    check_wb("mix_l4", 1'b1, 5'd4, 32'h44);
    step();
    check_wb("mix_l6", 1'b1, 5'd6, 32'h66);
    step();
    check("mix_idle_we", 64'(WE), 64'(0));
    check("mix_idle_rdy", 64'(ld_ready), 64'(1));

    // Issue to r9 in the same cycle its queued entry pops: set wins
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    ld_valid = 1'b1; ld_wa = 5'd9; ld_wd = 32'h99;
    step();
    ld_valid = 1'b0;
    check("r9_busy", 64'(busy), 64'(32'h200));
    step();
    ld_issue = 1'b0;
    check_wb("r9_pop", 1'b1, 5'd9, 32'h99);
    check("r9_busy_kept", 64'(busy), 64'(32'h200));
    ld_valid = 1'b1; ld_wd = 32'h9A;
    step();
    ld_valid = 1'b0;
    step();
    check_wb("r9_pop2", 1'b1, 5'd9, 32'h9A);
    check("r9_busy_clr", 64'(busy), 64'(0));

    // Register 0: issue ignored, entry pops without a write
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    step();
    ld_issue = 1'b0;
    check("r0_busy", 64'(busy), 64'(0));
    ld_valid = 1'b1; ld_wa = 5'd0; ld_wd = 32'hFFFF;
    step();
    ld_valid = 1'b0;
    check("r0_hs_we", 64'(WE), 64'(0));
    step();
    check("r0_pop_we", 64'(WE), 64'(0));
    check("r0_pop_busy", 64'(busy), 64'(0));
    check("r0_pop_rdy", 64'(ld_ready), 64'(1));

    // Fill queue behind ALU writes (one to a busy reg), then reset
    ld_issue = 1'b1; ld_issue_rd = 5'd10;
    alu_valid = 1'b1; alu_wa = 5'd12; alu_wd = 32'hC;
    ld_valid = 1'b1; ld_wa = 5'd10; ld_wd = 32'hA0;
    step();
    ld_issue = 1'b0;
    alu_wa = 5'd10; alu_wd = 32'h77; ld_wa = 5'd11; ld_wd = 32'hB0;
    check("fill_busy", 64'(busy), 64'(32'h400));
    step();
    check_wb("alu_busy_wr", 1'b1, 5'd10, 32'h77);
    check("alu_busy_keep", 64'(busy), 64'(32'h400));
    check("fill_full", 64'(ld_ready), 64'(0));
    reset = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
    step();
    reset = 1'b0;
    check("rst2_we", 64'(WE), 64'(0));
    check("rst2_busy", 64'(busy), 64'(0));
    check("rst2_rdy", 64'(ld_ready), 64'(1));
    step();
    check("rst2_we_a", 64'(WE), 64'(0));
    step();
    check("rst2_we_b", 64'(WE), 64'(0));
    check("rst2_rdy_b", 64'(ld_ready), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WIDTH, 32, data width; matches regfile WIDTH.
- DEPTH, 32, register count; address width AW = $clog2(DEPTH).
- QDEPTH, 2, load-return queue entries; power of two, at least 2.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock; all state updates on posedge.
- reset, in, 1, synchronous, active-high.
- alu_valid, in, 1, pipeline writeback valid; cannot be stalled.
- alu_wa, in, AW, pipeline destination register.
- alu_wd, in, WIDTH, pipeline write data.
- ld_issue, in, 1, load miss issued; marks its destination pending.
- ld_issue_rd, in, AW, destination register of the issued load.
- ld_valid, in, 1, load return data valid.
- ld_ready, out, 1, load return accepted this cycle when high.
- ld_wa, in, AW, load return destination.
- ld_wd, in, WIDTH, load return data.
- WE, out, 1, regfile write enable.
- WA, out, AW, regfile write address.
- WD, out, WIDTH, regfile write data.
- busy, out, DEPTH, scoreboard with one pending-load bit per register.

Function
REQ-003 WE, WA and WD SHALL be registered, so a write selected in cycle N appears on WE/WA/WD in cycle N+1.
REQ-004 The arbiter SHALL grant alu_valid over the queue head in every cycle.
REQ-005 An ALU write SHALL reach WE one cycle after alu_valid, with no stall.
REQ-006 A load return handshake SHALL occur when ld_valid and ld_ready are both high, and SHALL push {ld_wa, ld_wd} into the queue.
REQ-007 ld_ready SHALL equal "queue not full" and SHALL NOT depend on a same-cycle pop.
REQ-008 The queue head SHALL pop in a cycle where it is non-empty and alu_valid is low.
REQ-009 An accepted load SHALL have a minimum of 2 cycles from handshake to WE, and SHALL be issued in FIFO order.
REQ-010 The queue SHALL support simultaneous push and pop, and the occupancy count SHALL stay unchanged in that case.
REQ-011 The queue SHALL wrap its read and write pointers modulo QDEPTH.
REQ-012 A selected write with address 0 SHALL drive WE=0 in the following cycle; a queue entry with address 0 SHALL still pop.
REQ-013 ld_issue with ld_issue_rd!=0 SHALL set busy[ld_issue_rd] at the next edge; ld_issue with ld_issue_rd=0 SHALL be ignored.
REQ-014 busy[a] SHALL clear at the edge on which a queue entry with address a is popped.
REQ-015 When a set and a clear hit the same busy bit in the same cycle, the set SHALL win.
REQ-016 An ALU write to a register whose busy bit is set SHALL proceed and SHALL leave busy unchanged; ordering in that case is the hazard unit's responsibility.
REQ-017 busy[0] SHALL be constant 0.

Reset
REQ-018 While reset is high at a posedge, the block SHALL clear the queue pointers and count, busy, WE, WA and WD to 0.
REQ-019 Queue entries in flight when reset asserts SHALL be discarded and SHALL NOT be written to the regfile.
REQ-020 ld_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-021 WIDTH and DEPTH defaults and the zero-register address constant SHALL live in the shared MIPS defines package, which is also used by regfile.
REQ-022 The queue SHALL be a sub-module named wb_fifo, parameterised by entry width (AW+WIDTH) and QDEPTH, exposing push, pop, full, empty and head; wb_arbiter SHALL contain the arbitration and scoreboard logic.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- alu_valid=1, alu_wa=5, alu_wd=0xDEADBEEF for 1 cycle -> next cycle WE=1, WA=5, WD=0xDEADBEEF; the cycle after, WE=0.
- ld_issue rd=7; 3 cycles later ld_valid wa=7 wd=0x1234 with alu idle -> busy[7]=1 from issue+1; WE/WA=7/WD=0x1234 two cycles after handshake; busy[7]=0 on that same edge.
- alu_valid held 4 cycles while 3 loads return -> ld_ready drops after 2 accepts; all 4 ALU writes appear back-to-back; loads drain in arrival order once alu idles; the third load is accepted after the first pop.
- Same cycle: ld_issue rd=9 and pop of queued entry wa=9 -> busy[9] remains 1.
- ld_issue rd=0, then ld_valid wa=0 wd=0xFFFF -> busy stays 0; the entry pops; WE stays 0.
- Queue full (2 entries), reset for 1 cycle -> no WE afterwards, busy=0, ld_ready=1.
